// File: rtl/ntt_addrgen_param.sv
// ntt_addrgen_param: unified NTT/INTT butterfly address and twiddle-index generator
// with run-time mode latching, stall, abort and stage reporting.
`default_nettype none

module ntt_addrgen_param #(
  parameter int LOG_N        = 8,
  parameter int LAST_LEN_LOG = 1,
  parameter int SW           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_stall,
  input  logic             i_abort,
  output logic             o_valid,
  output logic [LOG_N-1:0] o_addr_up,
  output logic [LOG_N-1:0] o_addr_dn,
  output logic [LOG_N-2:0] o_zeta_idx,
  output logic [SW-1:0]    o_stage,
  output logic             o_last_stage,
  output logic             o_busy,
  output logic             o_done
);

  localparam int C_S  = LOG_N - LAST_LEN_LOG;
  localparam int C_CW = LOG_N - 1;
  localparam int C_LW = $clog2(LOG_N) + 1;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  localparam logic [C_CW-1:0] C_CNT_LAST   = '1;
  localparam logic [SW-1:0]   C_STAGE_LAST = SW'(C_S - 1);

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [C_CW-1:0]  cnt_q, cnt_d;

  logic [C_LW-1:0]  w_l;
  logic [C_LW-1:0]  w_inv_sh;
  logic [LOG_N-1:0] w_c;
  logic [LOG_N-1:0] w_g;
  logic [LOG_N-1:0] w_len;
  logic [LOG_N-1:0] w_up;
  logic [LOG_N-1:0] w_dn;
  logic [C_CW-1:0]  w_zeta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= C_IDLE;
      mode_q  <= 1'b0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_IDLE: begin
        if (i_start) begin
          state_d = C_RUN;
          mode_d  = i_mode;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      C_RUN: begin
        // Abort outranks both stall and completion.
        if (i_abort) begin
          state_d = C_IDLE;
          stage_d = '0;
          cnt_d   = '0;
        end else if (!i_stall) begin
          if (cnt_q == C_CNT_LAST) begin
            cnt_d = '0;
            if (stage_q == C_STAGE_LAST) begin
              state_d = C_DONE;
              stage_d = '0;
            end else begin
              stage_d = stage_q + SW'(1);
            end
          end else begin
            cnt_d = cnt_q + C_CW'(1);
          end
        end
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Upper address is the counter with a zero bit inserted at the span position.
  always_comb begin
    w_l      = mode_q ? (C_LW'(LAST_LEN_LOG) + C_LW'(stage_q))
                      : (C_LW'(LOG_N - 1) - C_LW'(stage_q));
    w_inv_sh = C_LW'(C_S) - C_LW'(stage_q);
    w_c      = {1'b0, cnt_q};
    w_g      = w_c >> w_l;
    w_len    = LOG_N'(1) << w_l;
    w_up     = ((w_g << 1) << w_l) | (w_c & (w_len - LOG_N'(1)));
    w_dn     = w_up | w_len;
    w_zeta   = mode_q ? ((C_CW'(1) << w_inv_sh) - C_CW'(1) - w_g[C_CW-1:0])
                      : ((C_CW'(1) << stage_q) + w_g[C_CW-1:0]);
  end

  always_comb begin
    o_valid      = 1'b0;
    o_addr_up    = '0;
    o_addr_dn    = '0;
    o_zeta_idx   = '0;
    o_stage      = '0;
    o_last_stage = 1'b0;
    o_busy       = 1'b0;
    o_done       = (state_q == C_DONE);
    if (state_q == C_RUN) begin
      o_valid      = ~i_stall;
      o_addr_up    = w_up;
      o_addr_dn    = w_dn;
      o_zeta_idx   = w_zeta;
      o_stage      = stage_q;
      o_last_stage = (stage_q == C_STAGE_LAST);
      o_busy       = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ntt_addrgen_param.sv
// tb_ntt_addrgen_param: randomized stall/abort/reset bench against an arithmetic reference model.
`default_nettype none

module tb_ntt_addrgen_param;

  localparam int LN    = 8;
  localparam int LL    = 1;
  localparam int S     = LN - LL;
  localparam int TOTAL = S * (1 << (LN - 1));
  localparam int STOT  = 3 * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0, i_mode = 1'b0, i_stall = 1'b0, i_abort = 1'b0;
  logic o_valid, o_last_stage, o_busy, o_done;
  logic [7:0] o_addr_up, o_addr_dn;
  logic [6:0] o_zeta_idx;
  logic [3:0] o_stage;

  logic s_start = 1'b0, s_zero = 1'b0;
  logic s_valid, s_last, s_busy, s_done;
  logic [3:0] s_up, s_dn, s_stage;
  logic [2:0] s_z;

  int tests = 0, fails = 0;
  int phase, k, vcount;
  logic m;
  int ks = 0, sdone = 0;

  always #5 clk = ~clk;

  ntt_addrgen_param #(.LOG_N(LN), .LAST_LEN_LOG(LL), .SW(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_stall(i_stall), .i_abort(i_abort), .o_valid(o_valid),
    .o_addr_up(o_addr_up), .o_addr_dn(o_addr_dn), .o_zeta_idx(o_zeta_idx),
    .o_stage(o_stage), .o_last_stage(o_last_stage), .o_busy(o_busy), .o_done(o_done));

  ntt_addrgen_param #(.LOG_N(4), .LAST_LEN_LOG(1), .SW(4)) u_small (
    .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_mode(s_zero),
    .i_stall(s_zero), .i_abort(s_zero), .o_valid(s_valid),
    .o_addr_up(s_up), .o_addr_dn(s_dn), .o_zeta_idx(s_z),
    .o_stage(s_stage), .o_last_stage(s_last), .o_busy(s_busy), .o_done(s_done));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // k-th issued butterfly of a run, straight from the span/group/offset rules.
  function automatic void exp_pair(input int logn, input int lastlen, input logic mode,
                                   input int kk, output int up, output int dn,
                                   output int z, output int s);
    int half, ns, c, l, len, g, j;
    half = 1 << (logn - 1);
    ns   = logn - lastlen;
    s    = kk / half;
    c    = kk % half;
    l    = mode ? (lastlen + s) : (logn - 1 - s);
    len  = 1 << l;
    g    = c / len;
    j    = c % len;
    up   = g * 2 * len + j;
    dn   = up + len;
    z    = mode ? ((1 << (ns - s)) - 1 - g) : ((1 << s) + g);
  endfunction

  // Expected phase: 0 idle, 1 run (k = butterflies issued so far), 2 done pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0;
      k     <= 0;
      m     <= 1'b0;
    end else begin
      case (phase)
        0: if (i_start) begin phase <= 1; k <= 0; m <= i_mode; end
        1: begin
          if (i_abort) phase <= 0;
          else if (!i_stall) begin
            k <= k + 1;
            if (k + 1 == TOTAL) phase <= 2;
          end
        end
        default: phase <= 0;
      endcase
    end
  end

  initial begin : compare
    int eu, ed, ez, es;
    logic ev, eb, edn, el;
    vcount = 0;
    forever begin
      @(negedge clk);
      eu = 0; ed = 0; ez = 0; es = 0;
      if (phase == 1) exp_pair(LN, LL, m, k, eu, ed, ez, es);
      eb  = (phase == 1);
      ev  = eb && !i_stall;
      edn = (phase == 2);
      el  = eb && (es == S - 1);
      chk("outputs",
          {o_valid, o_busy, o_done, o_last_stage, o_stage, o_addr_up, o_addr_dn, o_zeta_idx},
          {ev, eb, edn, el, 4'(es), 8'(eu), 8'(ed), 7'(ez)});
      if (ev) begin
        if (!m && k == 0)   chk("ntt_first",   {o_addr_up, o_addr_dn, o_zeta_idx}, {8'd0, 8'd128, 7'd1});
        if (!m && k == 127) chk("ntt_p127",    {o_addr_up, o_addr_dn, o_zeta_idx}, {8'd127, 8'd255, 7'd1});
        if (!m && k == 768) chk("ntt_s6first", {o_addr_up, o_addr_dn, o_zeta_idx}, {8'd0, 8'd2, 7'd64});
        if (!m && k == 895) chk("ntt_last",    {o_addr_up, o_addr_dn, o_zeta_idx}, {8'd253, 8'd255, 7'd127});
        if (m && k == 0)    chk("intt_first",  {o_addr_up, o_addr_dn, o_zeta_idx}, {8'd0, 8'd2, 7'd127});
        if (m && k == 1)    chk("intt_second", {o_addr_up, o_addr_dn, o_zeta_idx}, {8'd1, 8'd3, 7'd127});
        if (m && k == 2)    chk("intt_third",  {o_addr_up, o_addr_dn, o_zeta_idx}, {8'd4, 8'd6, 7'd126});
        if (m && k == 768)  chk("intt_s6first",{o_addr_up, o_addr_dn, o_zeta_idx}, {8'd0, 8'd128, 7'd1});
      end
      if (phase == 0) vcount = 0;
      if (o_valid === 1'b1) vcount++;
      if (phase == 2) chk("valid_count", vcount, TOTAL);
    end
  end

  initial begin : compare_small
    int u, d, z, s;
    forever begin
      @(negedge clk);
      if (s_valid === 1'b1) begin
        if (ks < STOT) begin
          exp_pair(4, 1, 1'b0, ks, u, d, z, s);
          chk("small_pair", {s_stage, s_up, s_dn, s_z}, {4'(s), 4'(u), 4'(d), 3'(z)});
          if (ks == 0)  chk("small_first", {s_up, s_dn, s_z}, {4'd0, 4'd8, 3'd1});
          if (ks == 8)  chk("small_s1",    {s_up, s_dn, s_z}, {4'd0, 4'd4, 3'd2});
          if (ks == 23) chk("small_last",  {s_up, s_dn, s_z}, {4'd13, 4'd15, 3'd7});
        end else begin
          chk("small_extra_valid", ks, STOT - 1);
        end
        ks++;
      end
      if (s_done === 1'b1) sdone++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (phase != 0 && n < 5000) begin tick(); n++; end
    if (n >= 5000) chk("wait_idle_timeout", n, 0);
  endtask

  task automatic begin_run(input logic mode, input logic with_abort);
    wait_idle();
    i_start = 1'b1; i_mode = mode; i_abort = with_abort;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
  endtask

  // Drives the rest of a run; noise toggles i_mode and pulses i_start mid-run.
  task automatic body(input int stall_pct, input logic noise, input int stop_k);
    int n = 0;
    while (phase != 0 && n < 20000 && !(phase == 1 && k == stop_k)) begin
      i_stall = ($urandom_range(99) < stall_pct);
      i_start = 1'b0;
      if (noise) begin
        i_mode  = 1'($urandom_range(1));
        i_start = (phase == 1) && ($urandom_range(9) == 0);
        if (phase == 2) i_start = 1'b1;
      end
      tick();
      n++;
    end
    if (n >= 20000) chk("run_timeout", n, 0);
    i_stall = 1'b0;
    i_start = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;

    begin_run(1'b0, 1'b0); body(0, 1'b0, -1);
    begin_run(1'b1, 1'b0); body(0, 1'b0, -1);
    begin_run(1'b0, 1'b0); body(30, 1'b1, -1);

    begin_run(1'b0, 1'b0); body(0, 1'b0, 300);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    repeat (2) tick();
    begin_run(1'b1, 1'b1); body(30, 1'b0, -1);

    begin_run(1'b0, 1'b0); body(0, 1'b0, 500);
    rst_n = 1'b0;
    #1;
    chk("reset_async_zero",
        {o_valid, o_busy, o_done, o_last_stage, o_stage, o_addr_up, o_addr_dn, o_zeta_idx}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    begin_run(1'b0, 1'b0); body(20, 1'b1, -1);
    wait_idle();
    repeat (3) tick();

    chk("small_count", ks, STOT);
    chk("small_done", sdone, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
